// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single data-cache port between address-generation reads and
// writeback writes. Accesses that straddle a cache-line boundary are issued
// as two beats. All outputs are registered and reset asynchronously.
// Beat byte counts are 4 bits wide, so the line must be at least 8 bytes
// (LINE_LOG2 >= 3); otherwise an access could exceed two beats.
module dcache_port_arbiter #(
   parameter int LINE_LOG2  = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RD_REQ,
   input  logic [31:0] RD_ADDR,
   input  logic [1:0]  RD_SIZE,
   output logic        RD_GNT,
   output logic        RD_DONE,
   input  logic        WR_REQ,
   input  logic [31:0] WR_ADDR,
   input  logic [1:0]  WR_SIZE,
   output logic        WR_GNT,
   output logic        WR_DONE,
   output logic        CACHE_V,
   output logic        CACHE_WR,
   output logic [31:0] CACHE_ADDR,
   output logic [3:0]  CACHE_BYTES,
   output logic        CACHE_HALF,
   input  logic        CACHE_ACK
);

   localparam logic [31:0] LINE_BYTES   = 32'd1 << LINE_LOG2;
   localparam logic [31:0] LINE_MASK    = LINE_BYTES - 32'd1;
   localparam logic [2:0]  STARVE_LIMIT = 3'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state_reg;
   logic [2:0]  starve_cnt_reg;
   logic        split_reg;        // current access needs a second beat
   logic [31:0] beat1_addr_reg;   // second-beat address, computed at grant
   logic [3:0]  beat1_bytes_reg;  // second-beat byte count, computed at grant

   logic        pick_any;
   logic        pick_wr;
   logic [31:0] sel_addr;
   logic [1:0]  sel_size;
   logic [3:0]  sel_n;
   logic [31:0] sel_off;
   logic [31:0] sel_end;
   logic        sel_split;
   logic [3:0]  sel_b0;
   logic [31:0] sel_next_line;
   logic [2:0]  starve_next;

   // Arbitrate between the two requesters and work out the beat geometry
   // of whichever one wins, so the grant cycle can load both beats at once.
   always_comb begin
      pick_any      = RD_REQ | WR_REQ;
      // Write has priority unless the pending read has waited long enough.
      pick_wr       = WR_REQ & (~RD_REQ | (starve_cnt_reg != STARVE_LIMIT));
      sel_addr      = pick_wr ? WR_ADDR : RD_ADDR;
      sel_size      = pick_wr ? WR_SIZE : RD_SIZE;
      sel_n         = 4'd1 << sel_size;
      sel_off       = sel_addr & LINE_MASK;
      sel_end       = sel_off + {28'd0, sel_n};
      sel_split     = sel_end > LINE_BYTES;
      // A split first beat runs to the end of the line; the rest follows.
      sel_b0        = sel_split ? 4'(LINE_BYTES - sel_off) : sel_n;
      // Start of the next line; wraps to 0 past the top of the address space.
      sel_next_line = (sel_addr & ~LINE_MASK) + LINE_BYTES;
      starve_next   = 3'd0;
      if (pick_wr && RD_REQ) begin
         starve_next = (starve_cnt_reg == STARVE_LIMIT) ? starve_cnt_reg
                                                        : starve_cnt_reg + 3'd1;
      end
   end

   // Port sequencer: grant in IDLE, present beats until acknowledged,
   // then pulse DONE for the direction that just finished.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg       <= IDLE;
         starve_cnt_reg  <= 3'd0;
         split_reg       <= 1'b0;
         beat1_addr_reg  <= 32'd0;
         beat1_bytes_reg <= 4'd0;
         RD_GNT          <= 1'b0;
         RD_DONE         <= 1'b0;
         WR_GNT          <= 1'b0;
         WR_DONE         <= 1'b0;
         CACHE_V         <= 1'b0;
         CACHE_WR        <= 1'b0;
         CACHE_ADDR      <= 32'd0;
         CACHE_BYTES     <= 4'd0;
         CACHE_HALF      <= 1'b0;
      end else begin
         RD_GNT  <= 1'b0;
         WR_GNT  <= 1'b0;
         RD_DONE <= 1'b0;
         WR_DONE <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  state_reg       <= BEAT0;
                  starve_cnt_reg  <= starve_next;
                  split_reg       <= sel_split;
                  beat1_addr_reg  <= sel_next_line;
                  beat1_bytes_reg <= sel_n - sel_b0;
                  RD_GNT          <= ~pick_wr;
                  WR_GNT          <= pick_wr;
                  CACHE_V         <= 1'b1;
                  CACHE_WR        <= pick_wr;
                  CACHE_ADDR      <= sel_addr;
                  CACHE_BYTES     <= sel_b0;
                  CACHE_HALF      <= 1'b0;
               end
            end
            BEAT0: begin
               if (CACHE_ACK) begin
                  if (split_reg) begin
                     state_reg   <= BEAT1;
                     CACHE_ADDR  <= beat1_addr_reg;
                     CACHE_BYTES <= beat1_bytes_reg;
                     CACHE_HALF  <= 1'b1;
                  end else begin
                     state_reg   <= IDLE;
                     RD_DONE     <= ~CACHE_WR;
                     WR_DONE     <= CACHE_WR;
                     CACHE_V     <= 1'b0;
                     CACHE_WR    <= 1'b0;
                     CACHE_ADDR  <= 32'd0;
                     CACHE_BYTES <= 4'd0;
                     CACHE_HALF  <= 1'b0;
                  end
               end
            end
            BEAT1: begin
               if (CACHE_ACK) begin
                  state_reg   <= IDLE;
                  RD_DONE     <= ~CACHE_WR;
                  WR_DONE     <= CACHE_WR;
                  CACHE_V     <= 1'b0;
                  CACHE_WR    <= 1'b0;
                  CACHE_ADDR  <= 32'd0;
                  CACHE_BYTES <= 4'd0;
                  CACHE_HALF  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: requester agents, a beat-queue reference
// model and a per-cycle compare, plus directed scenarios with literal values.
module tb_dcache_port_arbiter;

   localparam int LL = 4;
   localparam int SM = 3;
   localparam longint unsigned LB = 64'd16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        RD_REQ = 1'b0;
   logic [31:0] RD_ADDR = 32'd0;
   logic [1:0]  RD_SIZE = 2'd0;
   logic        RD_GNT;
   logic        RD_DONE;
   logic        WR_REQ = 1'b0;
   logic [31:0] WR_ADDR = 32'd0;
   logic [1:0]  WR_SIZE = 2'd0;
   logic        WR_GNT;
   logic        WR_DONE;
   logic        CACHE_V;
   logic        CACHE_WR;
   logic [31:0] CACHE_ADDR;
   logic [3:0]  CACHE_BYTES;
   logic        CACHE_HALF;
   logic        CACHE_ACK = 1'b0;

   always #5 CLK = ~CLK;

   dcache_port_arbiter #(.LINE_LOG2(LL), .STARVE_MAX(SM)) dut (
      .CLK(CLK), .RST(RST),
      .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_SIZE(RD_SIZE),
      .RD_GNT(RD_GNT), .RD_DONE(RD_DONE),
      .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_SIZE(WR_SIZE),
      .WR_GNT(WR_GNT), .WR_DONE(WR_DONE),
      .CACHE_V(CACHE_V), .CACHE_WR(CACHE_WR), .CACHE_ADDR(CACHE_ADDR),
      .CACHE_BYTES(CACHE_BYTES), .CACHE_HALF(CACHE_HALF), .CACHE_ACK(CACHE_ACK)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  bytes;
      logic        half;
      logic        wr;
   } beat_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
   } req_t;

   // reference model state: beats still owed to the cache for the current access
   beat_t beats[$];
   int    m_cnt = 0;
   int    beat_age = 0;
   bit    e_rgnt = 0, e_wgnt = 0, e_rdone = 0, e_wdone = 0;

   // requester agents
   req_t rdq[$];
   req_t wrq[$];
   int   rd_wait = 0, wr_wait = 0;
   bit   gaps = 0;
   int   ack_mode = 1;   // 0 random, 1 always, 2 after two wait cycles, 3 never

   int   errors = 0;
   int   checks = 0;
   int   rd_done_seen = 0;
   bit   gnt_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Split an access into line-bounded beats by plain arithmetic.
   function automatic int make_beats(input logic [31:0] addr, input logic [1:0] size,
                                     input logic wr, output beat_t b0, output beat_t b1);
      longint unsigned a = {32'd0, addr};
      longint unsigned n = 64'd1 << size;
      longint unsigned o = a % LB;
      b1 = '0;
      if (o + n > LB) begin
         b0 = '{addr: addr, bytes: 4'(LB - o), half: 1'b0, wr: wr};
         b1 = '{addr: 32'(a - o + LB), bytes: 4'(n - (LB - o)), half: 1'b1, wr: wr};
         return 2;
      end
      b0 = '{addr: addr, bytes: 4'(n), half: 1'b0, wr: wr};
      return 1;
   endfunction

   task automatic model_reset();
      beats.delete();
      m_cnt    = 0;
      beat_age = 0;
      e_rgnt   = 0;
      e_wgnt   = 0;
      e_rdone  = 0;
      e_wdone  = 0;
   endtask

   // Predict the next cycle from the inputs presented at the coming edge.
   task automatic model_advance(input bit rq, input bit wq, input bit ack,
                                input logic [31:0] ra, input logic [1:0] rs,
                                input logic [31:0] wa, input logic [1:0] ws);
      beat_t b0, b1;
      int    nb;
      bit    take_w, w;
      e_rgnt  = 0;
      e_wgnt  = 0;
      e_rdone = 0;
      e_wdone = 0;
      if (beats.size() == 0) begin
         if (rq || wq) begin
            take_w = wq && !(rq && m_cnt == SM);
            if (take_w) begin
               m_cnt  = rq ? ((m_cnt + 1 > SM) ? SM : m_cnt + 1) : 0;
               nb     = make_beats(wa, ws, 1'b1, b0, b1);
               e_wgnt = 1;
            end else begin
               m_cnt  = 0;
               nb     = make_beats(ra, rs, 1'b0, b0, b1);
               e_rgnt = 1;
            end
            beats.push_back(b0);
            if (nb == 2) beats.push_back(b1);
            beat_age = 0;
         end
      end else if (ack) begin
         w = beats[0].wr;
         void'(beats.pop_front());
         beat_age = 0;
         if (beats.size() == 0) begin
            if (w) e_wdone = 1;
            else   e_rdone = 1;
         end
      end else begin
         beat_age++;
      end
   endtask

   task automatic check_cycle();
      chk("rd_gnt",  32'(RD_GNT),  32'(e_rgnt));
      chk("wr_gnt",  32'(WR_GNT),  32'(e_wgnt));
      chk("rd_done", 32'(RD_DONE), 32'(e_rdone));
      chk("wr_done", 32'(WR_DONE), 32'(e_wdone));
      chk("cache_v", 32'(CACHE_V), 32'(beats.size() > 0));
      if (beats.size() > 0) begin
         chk("cache_addr",  CACHE_ADDR,        beats[0].addr);
         chk("cache_bytes", 32'(CACHE_BYTES),  32'(beats[0].bytes));
         chk("cache_half",  32'(CACHE_HALF),   32'(beats[0].half));
         chk("cache_wr",    32'(CACHE_WR),     32'(beats[0].wr));
      end
   endtask

   // One cycle: compare at the falling edge, then drive inputs and advance the model.
   task automatic step();
      bit rq, wq, ack;
      @(negedge CLK);
      check_cycle();
      if (RD_DONE) rd_done_seen++;
      if (RD_GNT || WR_GNT) gnt_log.push_back(WR_GNT);
      if (e_rgnt && rdq.size() > 0) begin
         void'(rdq.pop_front());
         rd_wait = gaps ? $urandom_range(0, 3) : 0;
      end
      if (e_wgnt && wrq.size() > 0) begin
         void'(wrq.pop_front());
         wr_wait = gaps ? $urandom_range(0, 3) : 0;
      end
      if (rd_wait > 0) rd_wait--;
      if (wr_wait > 0) wr_wait--;
      rq = (rdq.size() > 0) && (rd_wait == 0);
      wq = (wrq.size() > 0) && (wr_wait == 0);
      RD_REQ = rq;
      WR_REQ = wq;
      if (rq) begin RD_ADDR = rdq[0].addr; RD_SIZE = rdq[0].size; end
      else begin RD_ADDR = $urandom; RD_SIZE = 2'($urandom_range(0, 3)); end
      if (wq) begin WR_ADDR = wrq[0].addr; WR_SIZE = wrq[0].size; end
      else begin WR_ADDR = $urandom; WR_SIZE = 2'($urandom_range(0, 3)); end
      case (ack_mode)
         0:       ack = ($urandom_range(0, 2) != 0);
         1:       ack = 1'b1;
         2:       ack = (beats.size() > 0) && (beat_age >= 2);
         default: ack = 1'b0;
      endcase
      CACHE_ACK = ack;
      model_advance(rq, wq, ack, RD_ADDR, RD_SIZE, WR_ADDR, WR_SIZE);
   endtask

   // Step until the chosen output pulses: 0 RD_GNT, 1 WR_GNT, 2 RD_DONE, 3 WR_DONE.
   task automatic run_until(input int which, input int bound);
      bit hit = 0;
      for (int i = 0; i < bound && !hit; i++) begin
         step();
         case (which)
            0:       hit = RD_GNT;
            1:       hit = WR_GNT;
            2:       hit = RD_DONE;
            default: hit = WR_DONE;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wait_event%0d: got no pulse expected one within %0d cycles", which, bound);
      end
   endtask

   task automatic wait_idle(input int bound);
      bit done = 0;
      for (int i = 0; i < bound && !done; i++) begin
         step();
         done = (rdq.size() == 0) && (wrq.size() == 0) && (beats.size() == 0);
      end
      step();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: got busy expected idle within %0d cycles", bound);
      end
   endtask

   function automatic int log_bits();
      int v = 0;
      for (int i = 0; i < gnt_log.size(); i++) v = (v << 1) | int'(gnt_log[i]);
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_v"},     32'(CACHE_V),     32'd0);
      chk({tag, "_addr"},  CACHE_ADDR,       32'd0);
      chk({tag, "_bytes"}, 32'(CACHE_BYTES), 32'd0);
      chk({tag, "_flags"}, {26'd0, RD_GNT, WR_GNT, RD_DONE, WR_DONE, CACHE_WR, CACHE_HALF}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      beat_t b0, b1;
      int    nb;
      int    done_before;

      // pin the model's beat splitting with hand-computed values
      nb = make_beats(32'hFFFF_FFFE, 2'b11, 1'b1, b0, b1);
      chk("pin_wrap_n", 32'(nb), 32'd2);
      chk("pin_wrap_b0", {b0.addr[3:0], 24'd0, b0.bytes}, 32'hE000_0002);
      chk("pin_wrap_b1addr", b1.addr, 32'h0000_0000);
      chk("pin_wrap_b1bytes", 32'(b1.bytes), 32'd6);
      nb = make_beats(32'h0000_200E, 2'b10, 1'b0, b0, b1);
      chk("pin_split_b1", {b1.addr[15:0], 12'd0, b1.bytes}, 32'h2010_0002);
      nb = make_beats(32'h0000_100C, 2'b10, 1'b0, b0, b1);
      chk("pin_edge_unsplit", {nb[3:0], 24'd0, b0.bytes}, 32'h1000_0004);

      // reset state
      @(negedge CLK);
      check_all_zero("reset");
      @(posedge CLK);
      #2 RST = 1'b0;
      model_reset();
      step();

      // aligned read with zero-wait ACK
      ack_mode = 1;
      rdq.push_back('{addr: 32'h1000, size: 2'b10});
      run_until(0, 10);
      chk("aligned_v", 32'(CACHE_V), 32'd1);
      chk("aligned_addr", CACHE_ADDR, 32'h1000);
      chk("aligned_bytes", 32'(CACHE_BYTES), 32'd4);
      chk("aligned_wr_half", {30'd0, CACHE_WR, CACHE_HALF}, 32'd0);
      step();
      chk("aligned_done", 32'(RD_DONE), 32'd1);
      $display("aligned read done");
      wait_idle(20);

      // collision: write first, read the cycle after WR_DONE
      gnt_log.delete();
      rdq.push_back('{addr: 32'h3000, size: 2'b10});
      wrq.push_back('{addr: 32'h4000, size: 2'b10});
      run_until(3, 20);
      step();
      chk("collide_rd_after_wdone", 32'(RD_GNT), 32'd1);
      wait_idle(20);
      chk("collide_order", 32'(log_bits()), 32'b10);
      $display("collision done");

      // starvation: three writes, then the read, then the last write
      gnt_log.delete();
      rdq.push_back('{addr: 32'h5000, size: 2'b00});
      for (int i = 0; i < 4; i++) wrq.push_back('{addr: 32'h6000 + 32'(i * 8), size: 2'b11});
      wait_idle(60);
      chk("starve_order", 32'(log_bits()), 32'b11101);
      $display("starvation done");

      // split dword with two wait cycles per beat
      ack_mode = 2;
      done_before = rd_done_seen;
      rdq.push_back('{addr: 32'h200E, size: 2'b10});
      run_until(0, 10);
      chk("split_b0_addr", CACHE_ADDR, 32'h200E);
      chk("split_b0_bytes", 32'(CACHE_BYTES), 32'd2);
      chk("split_b0_half", 32'(CACHE_HALF), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("split_hold", {CACHE_ADDR[27:0], CACHE_BYTES}, {28'h000200E, 4'd2});
      end
      step();
      chk("split_b1_addr", CACHE_ADDR, 32'h2010);
      chk("split_b1_bytes", 32'(CACHE_BYTES), 32'd2);
      chk("split_b1_half", 32'(CACHE_HALF), 32'd1);
      wait_idle(20);
      chk("split_one_done", 32'(rd_done_seen - done_before), 32'd1);
      $display("split dword done");

      // wrap past the top of the address space
      ack_mode = 1;
      wrq.push_back('{addr: 32'hFFFF_FFFE, size: 2'b11});
      run_until(1, 10);
      chk("wrap_b0_addr", CACHE_ADDR, 32'hFFFF_FFFE);
      chk("wrap_b0_bytes_wr", {27'd0, CACHE_WR, CACHE_BYTES}, {27'd0, 1'b1, 4'd2});
      step();
      chk("wrap_b1_addr", CACHE_ADDR, 32'h0000_0000);
      chk("wrap_b1_bytes_wr_half", {26'd0, CACHE_WR, CACHE_HALF, CACHE_BYTES}, {26'd0, 1'b1, 1'b1, 4'd6});
      wait_idle(20);
      $display("wrap done");

      // reset during the second beat of a split read
      ack_mode = 3;
      rdq.push_back('{addr: 32'h200E, size: 2'b10});
      run_until(0, 10);
      ack_mode = 1;
      step();
      ack_mode = 3;
      step();
      chk("rstmid_in_beat1", 32'(CACHE_HALF), 32'd1);
      rdq.push_back('{addr: 32'h5000, size: 2'b00});
      step();
      done_before = rd_done_seen;
      #2 RST = 1'b1;
      #1;
      check_all_zero("rstmid_async");
      model_reset();
      @(posedge CLK);
      #2 RST = 1'b0;
      step();
      step();
      chk("rstmid_regrant", 32'(RD_GNT), 32'd1);
      chk("rstmid_regrant_addr", CACHE_ADDR, 32'h5000);
      chk("rstmid_regrant_bytes", 32'(CACHE_BYTES), 32'd1);
      ack_mode = 1;
      wait_idle(20);
      chk("rstmid_no_stale_done", 32'(rd_done_seen - done_before), 32'd1);
      $display("reset mid-split done");

      // randomized traffic against the model
      gaps = 1;
      ack_mode = 0;
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ra, wa;
         ra = $urandom;
         wa = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF0 | {28'd0, ra[3:0]};
         if ($urandom_range(0, 7) == 0) wa = 32'hFFFF_FFF0 | {28'd0, wa[3:0]};
         rdq.push_back('{addr: ra, size: 2'($urandom_range(0, 3))});
         wrq.push_back('{addr: wa, size: 2'($urandom_range(0, 3))});
      end
      wait_idle(20000);
      $display("random traffic done, checks so far %0d", checks);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
